// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel debouncer.
package debounce_pkg;

    localparam int unsigned DEF_CHANNELS      = 4;
    localparam int unsigned DEF_STABLE_CYCLES = 16;

    // Width of a counter that must reach STABLE_CYCLES-1; never narrower than 1 bit.
    function automatic int unsigned cnt_w(input int unsigned stable);
        return (stable < 1) ? 1 : $clog2(stable + 1);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchroniser, stability counter, registered
// output level and one-cycle rise/fall strobes.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter logic        RESET_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_in,
    input  logic i_sample_en,
    output logic o_out,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned     CW   = cnt_w(STABLE_CYCLES);
    localparam logic [CW-1:0]   LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]   ONE  = CW'(1);

    logic          r_sync0;
    logic          r_sync1;
    logic          r_out;
    logic          r_rise;
    logic          r_fall;
    logic [CW-1:0] r_cnt;

    // Synchronise the raw input every cycle, independent of the sample qualifier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync0 <= RESET_VAL;
            r_sync1 <= RESET_VAL;
        end else begin
            r_sync0 <= i_in;
            r_sync1 <= r_sync0;
        end
    end

    // Qualify a new level: any return to the current output restarts the count,
    // even on cycles without a sample tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out  <= RESET_VAL;
            r_cnt  <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (r_sync1 == r_out) begin
                r_cnt <= '0;
            end else if (i_sample_en && (r_cnt == LAST)) begin
                r_out  <= r_sync1;
                r_cnt  <= '0;
                r_rise <= r_sync1;
                r_fall <= ~r_sync1;
            end else if (i_sample_en) begin
                r_cnt <= r_cnt + ONE;
            end
        end
    end

    assign o_out  = r_out;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/multi_debounce.sv
// Multi-channel debouncer: one debounce_chan per input channel.
// Optional macro DEBOUNCE_IRQ_EN adds sticky change flags and an interrupt.
module multi_debounce
    import debounce_pkg::*;
#(
    parameter int unsigned          CHANNELS      = DEF_CHANNELS,
    parameter int unsigned          STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter logic [CHANNELS-1:0]  RESET_VAL     = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] in,
    input  logic                sample_en,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
`ifdef DEBOUNCE_IRQ_EN
    ,
    input  logic [CHANNELS-1:0] irq_mask,
    input  logic [CHANNELS-1:0] chg_clr,
    output logic [CHANNELS-1:0] chg,
    output logic                irq
`endif
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        debounce_chan #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .RESET_VAL     (RESET_VAL[g])
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_in        (in[g]),
            .i_sample_en (sample_en),
            .o_out       (out[g]),
            .o_rise      (rise[g]),
            .o_fall      (fall[g])
        );
    end

`ifdef DEBOUNCE_IRQ_EN
    logic [CHANNELS-1:0] r_chg;
    logic                r_irq;
    logic [CHANNELS-1:0] w_chg_next;

    // A strobe sets the sticky flag; a set in the same cycle overrides a clear.
    always_comb begin
        w_chg_next = (r_chg & ~chg_clr) | rise | fall;
    end

    // Register sticky flags and the masked interrupt request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chg <= '0;
            r_irq <= 1'b0;
        end else begin
            r_chg <= w_chg_next;
            r_irq <= |(w_chg_next & irq_mask);
        end
    end

    assign chg = r_chg;
    assign irq = r_irq;
`endif

endmodule
